ctrl_main_fsm: RTL and testbench
================================

# ctrl_main_fsm

Moore main controller for the multicycle ARM datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Produces the datapath steering and enable strobes. Its RegW, MemW and Branch outputs feed the conditional-logic stage directly downstream, which gates them with the condition check; NextPC is combined there with the gated Branch to form PCWrite.

## Interface
Parameters: none. State is a fixed 4-bit register.

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high
- Op  in  2  instruction bits [27:26]
- Funct  in  6  instruction bits [25:20]; Funct[5] = I (immediate), Funct[0] = L (load)
- IRWrite  out  1  load instruction register
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUResult
- ALUSrcA  out  1  ALU A select: 0 = register read data, 1 = PC
- ALUSrcB  out  2  ALU B select: 00 = register, 01 = extended immediate, 10 = constant 4
- ALUOp  out  1  1 = ALU decoder uses Funct; 0 = force ADD
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- NextPC  out  1  unconditional PC update
- RegW  out  1  register write request, before condition gating
- MemW  out  1  memory write request, before condition gating
- Branch  out  1  branch request, before condition gating
- State  out  4  current state code, for debug and verification

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
- Codes 11–15 are illegal. They behave as UNKNOWN.
- Outputs are a pure function of State (Moore). Any output not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, IRWrite=1, NextPC=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10. This computes PC+8 for R15 reads.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
- MEMRD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.
- UNKNOWN: all outputs 0.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=00 & Funct[5]=0 → EXECUTER; Op=00 & Funct[5]=1 → EXECUTEI; Op=01 → MEMADR; Op=10 → BRANCH; Op=11 → UNKNOWN.
  - MEMADR: Funct[0]=1 → MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH.
  - MEMWR→FETCH.
  - EXECUTER and EXECUTEI → ALUWB → FETCH.
  - BRANCH→FETCH.
  - UNKNOWN and illegal codes → FETCH.
- Op and Funct are sampled only in DECODE and MEMADR. They are ignored in all other states.
- The FSM does not evaluate the condition field. A failed condition is handled downstream; the FSM path is unchanged.

## Timing
- Reset: synchronous. With reset high at a rising edge, State becomes FETCH on that edge.
- While reset is held, State stays FETCH, so outputs show FETCH values: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, all other outputs 0.
- Reset asserted in any state, mid-instruction included, forces FETCH at the next edge. No writeback strobe is issued for the aborted instruction after that edge.
- Outputs change only after a clock edge. There is no combinational path from Op or Funct to any output.
- Instruction latency in cycles, FETCH to the next FETCH:
  - LDR: 5
  - STR: 4
  - data-processing: 4
  - B: 3
  - undefined: 3
- RegW is high for exactly 1 cycle per LDR and per data-processing instruction.
- MemW is high for exactly 1 cycle per STR.
- Branch is high for exactly 1 cycle per B.
- IRWrite and NextPC are high for exactly 1 cycle per instruction.

## Test plan
- Reset for 2 cycles, then release with Op=00 and Funct=000000 → State sequence 0,1,6,8,0. RegW=1 only in state 8. ALUOp=1 in state 6.
- Op=00, Funct=101000 (immediate) → State sequence 0,1,7,8,0. In state 7, ALUSrcB=01.
- Op=01, Funct=011001 (LDR) → State sequence 0,1,2,3,4,0. AdrSrc=1 in state 3. ResultSrc=01 and RegW=1 in state 4.
- Op=01, Funct=011000 (STR) → State sequence 0,1,2,5,0. MemW=1 only in state 5.
- Op=10 → State sequence 0,1,9,0. Branch=1 in state 9, ALUSrcB=01 in state 9. Op=11 → State sequence 0,1,10,0, with all outputs 0 in state 10.
- Assert reset while in MEMRD → State=0 next cycle, and RegW is never asserted. Toggle Op and Funct every cycle during FETCH, EXECUTER and ALUWB → no effect on the state sequence.

Source files
------------

// File: rtl/ctrl_main_fsm.sv
// rtl/ctrl_main_fsm.sv - Moore main controller for the multicycle ARM datapath
module ctrl_main_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ALUOp,
   output logic [1:0] ResultSrc,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_UNKNOWN  = 4'd10
   } state_t;

   typedef struct packed {
      logic       ir_write;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       alu_op;
      logic [1:0] result_src;
      logic       next_pc;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
   } ctrl_t;

   state_t state;
   state_t state_next;
   ctrl_t  ctrl;
   ctrl_t  ctrl_next;

   // Only the I and L bits of Funct steer the sequence.
   logic unused_funct;
   assign unused_funct = ^Funct[4:1];

   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
            c.ir_write   = 1'b1;
            c.next_pc    = 1'b1;
         end
         S_DECODE: begin
            // PC+8 lands in the result bus so R15 reads see it.
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_MEMADR: begin
            c.alu_src_b  = 2'b01;
         end
         S_MEMRD: begin
            c.adr_src    = 1'b1;
         end
         S_MEMWB: begin
            c.result_src = 2'b01;
            c.reg_w      = 1'b1;
         end
         S_MEMWR: begin
            c.adr_src    = 1'b1;
            c.mem_w      = 1'b1;
         end
         S_EXECUTER: begin
            c.alu_op     = 1'b1;
         end
         S_EXECUTEI: begin
            c.alu_src_b  = 2'b01;
            c.alu_op     = 1'b1;
         end
         S_ALUWB: begin
            c.reg_w      = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_b  = 2'b01;
            c.result_src = 2'b10;
            c.branch     = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            case (Op)
               2'b00:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b01:   state_next = S_MEMADR;
               2'b10:   state_next = S_BRANCH;
               default: state_next = S_UNKNOWN;
            endcase
         end
         S_MEMADR:   state_next = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:    state_next = S_MEMWB;
         S_EXECUTER: state_next = S_ALUWB;
         S_EXECUTEI: state_next = S_ALUWB;
         default:    state_next = S_FETCH;
      endcase
   end

   assign ctrl_next = decode_ctrl(state_next);

   // Outputs are decoded from the next state so they are registered yet
   // always match the State register in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
         ctrl  <= decode_ctrl(S_FETCH);
      end else begin
         state <= state_next;
         ctrl  <= ctrl_next;
      end
   end

   assign IRWrite   = ctrl.ir_write;
   assign AdrSrc    = ctrl.adr_src;
   assign ALUSrcA   = ctrl.alu_src_a;
   assign ALUSrcB   = ctrl.alu_src_b;
   assign ALUOp     = ctrl.alu_op;
   assign ResultSrc = ctrl.result_src;
   assign NextPC    = ctrl.next_pc;
   assign RegW      = ctrl.reg_w;
   assign MemW      = ctrl.mem_w;
   assign Branch    = ctrl.branch;
   assign State     = state;

endmodule

// File: tb/tb_ctrl_main_fsm.sv
// tb/tb_ctrl_main_fsm.sv - scoreboard bench for ctrl_main_fsm
module tb_ctrl_main_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch;
   logic [1:0] ALUSrcB, ResultSrc;
   logic [3:0] State;

   ctrl_main_fsm dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW),
      .MemW(MemW), .Branch(Branch), .State(State)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] st;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   regw_seen = 0;

   // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, NextPC, RegW, MemW, Branch}
   function automatic logic [12:0] exp_ctrl(input logic [3:0] s);
      case (s)
         4'd0:    return 13'b1_0_1_10_0_10_1_0_0_0;
         4'd1:    return 13'b0_0_1_10_0_10_0_0_0_0;
         4'd2:    return 13'b0_0_0_01_0_00_0_0_0_0;
         4'd3:    return 13'b0_1_0_00_0_00_0_0_0_0;
         4'd4:    return 13'b0_0_0_00_0_01_0_1_0_0;
         4'd5:    return 13'b0_1_0_00_0_00_0_0_1_0;
         4'd6:    return 13'b0_0_0_00_1_00_0_0_0_0;
         4'd7:    return 13'b0_0_0_01_1_00_0_0_0_0;
         4'd8:    return 13'b0_0_0_00_0_00_0_1_0_0;
         4'd9:    return 13'b0_0_0_01_0_10_0_0_0_1;
         default: return 13'b0;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [12:0] act;
      logic [12:0] exp_c;
      exp_t        e;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         act = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, NextPC, RegW, MemW, Branch};
         exp_c = exp_ctrl(e.st);
         if (RegW) regw_seen = regw_seen + 1;
         checks = checks + 1;
         if (e.cyc != cyc || State !== e.st) begin
            failures = failures + 1;
            $display("FAIL state cyc=%0d actual=%0d expected=%0d (exp cyc %0d)", cyc, State, e.st, e.cyc);
         end
         checks = checks + 1;
         if (act !== exp_c) begin
            failures = failures + 1;
            $display("FAIL ctrl cyc=%0d state=%0d actual=%b expected=%b", cyc, e.st, act, exp_c);
         end
      end
   end

   task automatic step(input logic r, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] es);
      exp_t e;
      @(posedge clk);
      #1;
      reset = r;
      Op    = op;
      Funct = f;
      e.cyc = cyc + 1;
      e.st  = es;
      q.push_back(e);
   endtask

   initial begin
      reset = 1'b1;
      Op    = 2'b00;
      Funct = 6'b0;

      // reset held two cycles
      step(1'b1, 2'b00, 6'b000000, 4'd0);
      step(1'b1, 2'b00, 6'b000000, 4'd0);
      // data-processing register
      step(1'b0, 2'b00, 6'b000000, 4'd1);
      step(1'b0, 2'b00, 6'b000000, 4'd6);
      step(1'b0, 2'b00, 6'b000000, 4'd8);
      step(1'b0, 2'b00, 6'b000000, 4'd0);
      // data-processing immediate
      step(1'b0, 2'b00, 6'b101000, 4'd1);
      step(1'b0, 2'b00, 6'b101000, 4'd7);
      step(1'b0, 2'b00, 6'b101000, 4'd8);
      step(1'b0, 2'b00, 6'b101000, 4'd0);
      // LDR
      step(1'b0, 2'b01, 6'b011001, 4'd1);
      step(1'b0, 2'b01, 6'b011001, 4'd2);
      step(1'b0, 2'b01, 6'b011001, 4'd3);
      step(1'b0, 2'b01, 6'b011001, 4'd4);
      step(1'b0, 2'b01, 6'b011001, 4'd0);
      // STR
      step(1'b0, 2'b01, 6'b011000, 4'd1);
      step(1'b0, 2'b01, 6'b011000, 4'd2);
      step(1'b0, 2'b01, 6'b011000, 4'd5);
      step(1'b0, 2'b01, 6'b011000, 4'd0);
      // B
      step(1'b0, 2'b10, 6'b000000, 4'd1);
      step(1'b0, 2'b10, 6'b000000, 4'd9);
      step(1'b0, 2'b10, 6'b000000, 4'd0);
      // undefined
      step(1'b0, 2'b11, 6'b000000, 4'd1);
      step(1'b0, 2'b11, 6'b000000, 4'd10);
      step(1'b0, 2'b11, 6'b000000, 4'd0);
      // LDR aborted by reset while in MEMRD
      step(1'b0, 2'b01, 6'b011001, 4'd1);
      step(1'b0, 2'b01, 6'b011001, 4'd2);
      step(1'b0, 2'b01, 6'b011001, 4'd3);
      step(1'b1, 2'b01, 6'b011001, 4'd0);
      // data-processing with Op/Funct toggling outside DECODE
      step(1'b0, 2'b11, 6'b111111, 4'd1);
      step(1'b0, 2'b00, 6'b000000, 4'd6);
      step(1'b0, 2'b11, 6'b111111, 4'd8);
      step(1'b0, 2'b10, 6'b101001, 4'd0);
      step(1'b0, 2'b01, 6'b010101, 4'd1);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      checks = checks + 1;
      if (q.size() != 0) begin
         failures = failures + 1;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      checks = checks + 1;
      if (regw_seen != 4) begin
         failures = failures + 1;
         $display("FAIL regw_cycles actual=%0d required=4", regw_seen);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
